// File: rtl/quad_encoder_emulator_pkg.sv
// Shared definitions for the A/B/Z quadrature encoder emulator: default
// widths, quarter-step phase constants with their A/B levels, FSM states.
package quad_encoder_emulator_pkg;

    localparam int PPR_W_DEF  = 16;
    localparam int DIV_W_DEF  = 16;
    localparam int STEP_W_DEF = 32;
    localparam int REV_W      = 16;

    // Quarter-step phase numbers (position within one encoder pulse)
    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    // A/B output levels for each phase, packed as {A, B}
    localparam logic [1:0] AB_PH0 = 2'b00;
    localparam logic [1:0] AB_PH1 = 2'b10;
    localparam logic [1:0] AB_PH2 = 2'b11;
    localparam logic [1:0] AB_PH3 = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Gray-style mapping from phase number to {A, B}
    function automatic logic [1:0] phase_to_ab(input logic [1:0] ph);
        logic [1:0] ab;
        case (ph)
            PH0:     ab = AB_PH0;
            PH1:     ab = AB_PH1;
            PH2:     ab = AB_PH2;
            PH3:     ab = AB_PH3;
            default: ab = AB_PH0;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/quad_encoder_emulator_step_tick.sv
// Quarter-step rate generator: a loadable down-counter that raises tick for
// one cycle every (reload + 1) enabled cycles. The reload value is captured
// on load so later changes to the source have no effect on a running count.
module quad_encoder_emulator_step_tick
    import quad_encoder_emulator_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             Clk,
    input  logic             rset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] reload_r;

    // tick is combinational so the step lands on the same edge the count expires
    assign tick = en & (cnt_r == {DIV_W{1'b0}});

    // Down-counter with clear, load and automatic reload on tick
    always_ff @(posedge Clk or negedge rset_n) begin
        if (!rset_n) begin
            cnt_r    <= {DIV_W{1'b0}};
            reload_r <= {DIV_W{1'b0}};
        end else if (clr) begin
            cnt_r    <= {DIV_W{1'b0}};
        end else if (load) begin
            cnt_r    <= load_val;
            reload_r <= load_val;
        end else if (tick) begin
            cnt_r    <= reload_r;
        end else if (en) begin
            cnt_r    <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r    <= cnt_r;
        end
    end

endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: produces A/B/Z waveforms for tester loopback.
// Holds the run FSM, the shaft position (phase, pulse index, revolutions),
// and the registered encoder outputs. Position persists between runs.
module quad_encoder_emulator
    import quad_encoder_emulator_pkg::*;
#(
    parameter int PPR_W  = PPR_W_DEF,
    parameter int DIV_W  = DIV_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              Clk,
    input  logic              rset_n,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Dir,
    input  logic              Continuous,
    input  logic [STEP_W-1:0] Steps,
    input  logic [PPR_W-1:0]  PPR,
    input  logic [DIV_W-1:0]  Div,
    output logic              AOut,
    output logic              BOut,
    output logic              ZOut,
    output logic [PPR_W-1:0]  Index,
    output logic [REV_W-1:0]  Rev,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [PPR_W-1:0]  IDX_ONE  = {{(PPR_W-1){1'b0}}, 1'b1};
    localparam logic [REV_W-1:0]  REV_ONE  = {{(REV_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_nxt_s;
    logic              dir_r, cont_r;
    logic [STEP_W-1:0] remain_r;
    logic [PPR_W-1:0]  ppr_r, index_r;
    logic [REV_W-1:0]  rev_r;
    logic [1:0]        phase_r;
    logic              a_r, b_r, z_r, busy_r, done_r, err_r;

    logic              accept_s, reject_s, step_s, clr_s, tick_s;
    logic [DIV_W-1:0]  div_m1_s;
    logic [PPR_W-1:0]  ppr_m1_s;
    logic [1:0]        ph_nxt_s;
    logic [PPR_W-1:0]  idx_nxt_s;
    logic [REV_W-1:0]  rev_nxt_s;
    logic              z_nxt_s;

    // Div of 0 behaves like 1; the tick counter wants the period minus one
    always_comb begin
        if (Div == {DIV_W{1'b0}}) begin
            div_m1_s = {DIV_W{1'b0}};
        end else begin
            div_m1_s = Div - {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    quad_encoder_emulator_step_tick #(
        .DIV_W (DIV_W)
    ) u_step_tick (
        .Clk      (Clk),
        .rset_n   (rset_n),
        .clr      (clr_s),
        .load     (accept_s),
        .load_val (div_m1_s),
        .en       (state_r == ST_RUN),
        .tick     (tick_s)
    );

    // Run FSM: accept/reject Start, count steps, Abort wins over a step
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        step_s      = 1'b0;
        clr_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Abort also blocks a Start in the same cycle
                if (Start && !Abort) begin
                    if (PPR != {PPR_W{1'b0}}) begin
                        accept_s = 1'b1;
                        if (!Continuous && (Steps == {STEP_W{1'b0}})) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else begin
                        reject_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (Abort) begin
                    clr_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (tick_s) begin
                    step_s = 1'b1;
                    if (!cont_r && (remain_r == STEP_ONE)) begin
                        clr_s       = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                clr_s       = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign ppr_m1_s = ppr_r - IDX_ONE;

    // Next position for one quarter-step in the latched direction
    always_comb begin
        ph_nxt_s  = phase_r;
        idx_nxt_s = index_r;
        rev_nxt_s = rev_r;
        if (!dir_r) begin
            case (phase_r)
                PH0:     ph_nxt_s = PH1;
                PH1:     ph_nxt_s = PH2;
                PH2:     ph_nxt_s = PH3;
                PH3:     ph_nxt_s = PH0;
                default: ph_nxt_s = PH0;
            endcase
            if (phase_r == PH3) begin
                // >= lets an index left over from a larger PPR fall back in range
                if (index_r >= ppr_m1_s) begin
                    idx_nxt_s = {PPR_W{1'b0}};
                    rev_nxt_s = rev_r + REV_ONE;
                end else begin
                    idx_nxt_s = index_r + IDX_ONE;
                end
            end else begin
                idx_nxt_s = index_r;
            end
        end else begin
            case (phase_r)
                PH0:     ph_nxt_s = PH3;
                PH1:     ph_nxt_s = PH0;
                PH2:     ph_nxt_s = PH1;
                PH3:     ph_nxt_s = PH2;
                default: ph_nxt_s = PH0;
            endcase
            if (phase_r == PH0) begin
                if (index_r == {PPR_W{1'b0}}) begin
                    idx_nxt_s = ppr_m1_s;
                    rev_nxt_s = rev_r - REV_ONE;
                end else begin
                    idx_nxt_s = index_r - IDX_ONE;
                end
            end else begin
                idx_nxt_s = index_r;
            end
        end
        z_nxt_s = (ph_nxt_s == PH0) && (idx_nxt_s == {PPR_W{1'b0}});
    end

    // FSM state and status pulses
    always_ff @(posedge Clk or negedge rset_n) begin
        if (!rset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
            err_r   <= reject_s;
        end
    end

    // Run configuration captured at Start and the remaining-step counter
    always_ff @(posedge Clk or negedge rset_n) begin
        if (!rset_n) begin
            dir_r    <= 1'b0;
            cont_r   <= 1'b0;
            remain_r <= {STEP_W{1'b0}};
            ppr_r    <= {PPR_W{1'b0}};
        end else if (accept_s) begin
            dir_r    <= Dir;
            cont_r   <= Continuous;
            remain_r <= Steps;
            ppr_r    <= PPR;
        end else if (step_s && !cont_r) begin
            remain_r <= remain_r - STEP_ONE;
        end else begin
            remain_r <= remain_r;
        end
    end

    // Shaft position and encoder outputs, updated only on a quarter-step
    always_ff @(posedge Clk or negedge rset_n) begin
        if (!rset_n) begin
            phase_r <= PH0;
            index_r <= {PPR_W{1'b0}};
            rev_r   <= {REV_W{1'b0}};
            a_r     <= 1'b0;
            b_r     <= 1'b0;
            z_r     <= 1'b0;
        end else if (step_s) begin
            phase_r      <= ph_nxt_s;
            index_r      <= idx_nxt_s;
            rev_r        <= rev_nxt_s;
            {a_r, b_r}   <= phase_to_ab(ph_nxt_s);
            z_r          <= z_nxt_s;
        end else begin
            phase_r <= phase_r;
        end
    end

    assign AOut  = a_r;
    assign BOut  = b_r;
    assign ZOut  = z_r;
    assign Index = index_r;
    assign Rev   = rev_r;
    assign Busy  = busy_r;
    assign Done  = done_r;
    assign Err   = err_r;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Scoreboard bench for quad_encoder_emulator: stimulus pushes expected
// edge/Done/Err events (with the cycle they must appear in); a monitor pops
// and compares whenever the outputs show such an event.
module tb_quad_encoder_emulator;

    logic        Clk;
    logic        rset_n;
    logic        Start, Abort, Dir, Continuous;
    logic [31:0] Steps;
    logic [15:0] PPR, Div;
    logic        AOut, BOut, ZOut, Busy, Done, Err;
    logic [15:0] Index, Rev;

    quad_encoder_emulator #(
        .PPR_W  (16),
        .DIV_W  (16),
        .STEP_W (32)
    ) dut (
        .Clk        (Clk),
        .rset_n     (rset_n),
        .Start      (Start),
        .Abort      (Abort),
        .Dir        (Dir),
        .Continuous (Continuous),
        .Steps      (Steps),
        .PPR        (PPR),
        .Div        (Div),
        .AOut       (AOut),
        .BOut       (BOut),
        .ZOut       (ZOut),
        .Index      (Index),
        .Rev        (Rev),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err)
    );

    localparam logic [1:0] K_STEP = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  ab;
        logic        z;
        logic [15:0] idx;
        logic [15:0] rev;
        logic [31:0] cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    int  cyc    = 0;
    int  s;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_step(input logic [1:0] ab, input logic z, input logic [15:0] idx,
                             input logic [15:0] rev, input int c);
        ev_t e;
        e.kind = K_STEP; e.ab = ab; e.z = z; e.idx = idx; e.rev = rev; e.cyc = 32'(c);
        exp_q.push_back(e);
    endtask

    task automatic push_flag(input logic [1:0] kind, input int c);
        ev_t e;
        e = '0;
        e.kind = kind; e.cyc = 32'(c);
        exp_q.push_back(e);
    endtask

    task automatic sb_compare(input ev_t obs);
        ev_t ex;
        if (exp_q.size() == 0) begin
            chk("sb_extra_event", {27'd0, obs}, 96'd0);
        end else begin
            ex = exp_q.pop_front();
            chk("sb_event", {27'd0, obs}, {27'd0, ex});
        end
    endtask

    // Monitor: an A/B change, a Done pulse or an Err pulse is an observed event
    initial begin
        logic [1:0] prev_ab;
        ev_t        obs;
        prev_ab = 2'b00;
        forever begin
            @(negedge Clk);
            if (!rset_n) begin
                prev_ab = 2'b00;
            end else begin
                if ({AOut, BOut} != prev_ab) begin
                    obs.kind = K_STEP; obs.ab = {AOut, BOut}; obs.z = ZOut;
                    obs.idx = Index; obs.rev = Rev; obs.cyc = 32'(cyc);
                    prev_ab = {AOut, BOut};
                    sb_compare(obs);
                end
                if (Done) begin
                    obs = '0; obs.kind = K_DONE; obs.cyc = 32'(cyc);
                    sb_compare(obs);
                end
                if (Err) begin
                    obs = '0; obs.kind = K_ERR; obs.cyc = 32'(cyc);
                    sb_compare(obs);
                end
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge Clk);
    endtask

    // Called at a negedge; Start is sampled on the following posedge
    task automatic issue(input logic dir, input logic cont, input logic [31:0] steps,
                         input logic [15:0] ppr, input logic [15:0] div);
        Dir = dir; Continuous = cont; Steps = steps; PPR = ppr; Div = div;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    initial begin
        logic [1:0] ab_of [4];
        ab_of[0] = 2'b00; ab_of[1] = 2'b10; ab_of[2] = 2'b11; ab_of[3] = 2'b01;
        rset_n = 1'b0; Start = 1'b0; Abort = 1'b0; Dir = 1'b0; Continuous = 1'b0;
        Steps = 32'd0; PPR = 16'd0; Div = 16'd0;
        repeat (3) @(negedge Clk);
        chk("reset_outputs", {58'd0, AOut, BOut, ZOut, Busy, Done, Err, Index, Rev}, 96'd0);
        rset_n = 1'b1;
        @(negedge Clk);
        chk("post_reset_outputs", {58'd0, AOut, BOut, ZOut, Busy, Done, Err, Index, Rev}, 96'd0);

        // Forward 16 quarter-steps, PPR 4, Div 2: one full revolution
        s = cyc + 1;
        for (int k = 1; k <= 16; k++) begin
            push_step(ab_of[k % 4], (k == 16), 16'((k / 4) % 4), (k == 16) ? 16'd1 : 16'd0, s + 2 * k);
        end
        push_flag(K_DONE, s + 32);
        issue(1'b0, 1'b0, 32'd16, 16'd4, 16'd2);
        chk("busy_after_start", {95'd0, Busy}, {95'd0, 1'b1});
        wait_to(s + 33);
        chk("busy_after_done", {95'd0, Busy}, 96'd0);
        chk("pos_after_rev", {61'd0, AOut, BOut, ZOut, Index, Rev}, {61'd0, 2'b00, 1'b1, 16'd0, 16'd1});

        // One reverse step wraps Index down, then one forward step wraps it back
        s = cyc + 1;
        push_step(2'b01, 1'b0, 16'd3, 16'd0, s + 2);
        push_flag(K_DONE, s + 2);
        issue(1'b1, 1'b0, 32'd1, 16'd4, 16'd2);
        wait_to(s + 3);
        s = cyc + 1;
        push_step(2'b00, 1'b1, 16'd0, 16'd1, s + 2);
        push_flag(K_DONE, s + 2);
        issue(1'b0, 1'b0, 32'd1, 16'd4, 16'd2);
        wait_to(s + 3);

        // Continuous, Div 0, PPR 2; Abort blocks the 7th step
        s = cyc + 1;
        push_step(2'b10, 1'b0, 16'd0, 16'd1, s + 1);
        push_step(2'b11, 1'b0, 16'd0, 16'd1, s + 2);
        push_step(2'b01, 1'b0, 16'd0, 16'd1, s + 3);
        push_step(2'b00, 1'b0, 16'd1, 16'd1, s + 4);
        push_step(2'b10, 1'b0, 16'd1, 16'd1, s + 5);
        push_step(2'b11, 1'b0, 16'd1, 16'd1, s + 6);
        issue(1'b0, 1'b1, 32'd0, 16'd2, 16'd0);
        wait_to(s + 6);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk("busy_after_abort", {95'd0, Busy}, 96'd0);
        chk("pos_after_abort", {61'd0, AOut, BOut, ZOut, Index, Rev}, {61'd0, 2'b11, 1'b0, 16'd1, 16'd1});
        wait_to(s + 12);

        // PPR 0 is rejected with an Err pulse
        s = cyc + 1;
        push_flag(K_ERR, s);
        issue(1'b0, 1'b0, 32'd8, 16'd0, 16'd2);
        chk("busy_after_err", {95'd0, Busy}, 96'd0);
        chk("pos_after_err", {61'd0, AOut, BOut, ZOut, Index, Rev}, {61'd0, 2'b11, 1'b0, 16'd1, 16'd1});
        wait_to(s + 3);

        // Counted run of zero steps: Done at once, no edges
        s = cyc + 1;
        push_flag(K_DONE, s);
        issue(1'b0, 1'b0, 32'd0, 16'd5, 16'd2);
        chk("busy_zero_steps", {95'd0, Busy}, 96'd0);
        wait_to(s + 4);

        // Mid-run Start and config changes must not disturb a 4-step Div 3 run
        s = cyc + 1;
        push_step(2'b01, 1'b0, 16'd1, 16'd1, s + 3);
        push_step(2'b00, 1'b0, 16'd2, 16'd1, s + 6);
        push_step(2'b10, 1'b0, 16'd2, 16'd1, s + 9);
        push_step(2'b11, 1'b0, 16'd2, 16'd1, s + 12);
        push_flag(K_DONE, s + 12);
        issue(1'b0, 1'b0, 32'd4, 16'd4, 16'd3);
        wait_to(s + 4);
        issue(1'b1, 1'b0, 32'd100, 16'd4, 16'd1);
        wait_to(s + 14);
        chk("busy_after_ignored_start", {95'd0, Busy}, 96'd0);

        // Asynchronous reset in the middle of a run
        s = cyc + 1;
        push_step(2'b01, 1'b0, 16'd2, 16'd1, s + 3);
        push_step(2'b00, 1'b0, 16'd3, 16'd1, s + 6);
        issue(1'b0, 1'b0, 32'd10, 16'd4, 16'd3);
        wait_to(s + 7);
        @(posedge Clk);
        #2 rset_n = 1'b0;
        #1 chk("async_reset_outputs", {58'd0, AOut, BOut, ZOut, Busy, Done, Err, Index, Rev}, 96'd0);
        @(negedge Clk);
        @(negedge Clk);
        rset_n = 1'b1;
        @(negedge Clk);
        chk("after_reset_release", {58'd0, AOut, BOut, ZOut, Busy, Done, Err, Index, Rev}, 96'd0);
        s = cyc + 1;
        push_step(2'b10, 1'b0, 16'd0, 16'd0, s + 1);
        push_flag(K_DONE, s + 1);
        issue(1'b0, 1'b0, 32'd1, 16'd4, 16'd1);
        wait_to(s + 4);
        chk("busy_final", {95'd0, Busy}, 96'd0);

        chk("sb_all_events_seen", {64'd0, 32'(exp_q.size())}, 96'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
